// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data memory port arbiter:
//   - arb_state_e : arbiter FSM states (ARB_IDLE, ARB_WAIT)
//   - owner_e     : which requester owns the read in flight (OWN_I, OWN_D)
//   - MEM_FN_*    : memory command codes shared with the pipeline decoder.
//                   The arbiter forwards d_fn untouched; instruction fetches
//                   always present MEM_FN_NONE to the memory.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [2:0] MEM_FN_NONE = 3'd0;
  localparam logic [2:0] MEM_FN_B    = 3'd1;
  localparam logic [2:0] MEM_FN_H    = 3'd2;
  localparam logic [2:0] MEM_FN_W    = 3'd3;
  localparam logic [2:0] MEM_FN_BU   = 3'd5;
  localparam logic [2:0] MEM_FN_HU   = 3'd6;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port (i_*), the data port (d_*), the memory command/data
// port (m_*) and the busy flag of mem_port_arbiter.
//   modport slave  : the arbiter's view (requests and m_rdata in; grants,
//                    read data, memory command and busy out)
//   modport master : the surrounding pipeline/memory view (the mirror image)
// Parameters: DATA_LEN (data width), MEM_ADDR_LEN (byte-address width).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int DATA_LEN     = 32,
  parameter int MEM_ADDR_LEN = 32
);
  // fetch port
  logic                    i_req;
  logic [MEM_ADDR_LEN-1:0] i_addr;
  logic                    i_gnt;
  logic                    i_rvalid;
  logic [DATA_LEN-1:0]     i_rdata;
  // data port
  logic                    d_req;
  logic                    d_we;
  logic [MEM_ADDR_LEN-1:0] d_addr;
  logic [DATA_LEN-1:0]     d_wdata;
  logic [2:0]              d_fn;
  logic                    d_gnt;
  logic                    d_rvalid;
  logic [DATA_LEN-1:0]     d_rdata;
  // memory port
  logic                    m_en;
  logic                    m_we;
  logic [MEM_ADDR_LEN-1:0] m_addr;
  logic [DATA_LEN-1:0]     m_wdata;
  logic [2:0]              m_fn;
  logic [DATA_LEN-1:0]     m_rdata;
  // status
  logic                    busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_fn, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata, m_fn, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_fn, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_fn, busy
  );
endinterface

// File: rtl/mem_arb_prio.sv
// ---------------------------------------------------------------------------
// mem_arb_prio
// Combinational winner select between fetch and data requests, plus the
// optional fetch starvation counter.
// Optional feature macro: ARB_STARVE_GUARD_EN. When defined, a 4-bit counter
// tracks data grants made while a fetch is waiting; once it reaches
// STARVE_LIMIT the fetch wins the next arbitration even if d_req is high.
// When undefined, data always wins and no counter (nor clk/reset) exists.
// Ports:
//   clk, reset    : clock / async active-high reset (guard build only)
//   arb_en        : a grant may be issued this cycle
//   i_req, d_req  : fetch / data requests
//   i_win, d_win  : one-hot (or zero) winner, already qualified by arb_en
// ---------------------------------------------------------------------------
module mem_arb_prio
`ifdef ARB_STARVE_GUARD_EN
#(
  parameter int STARVE_LIMIT = 4
)
`endif
(
`ifdef ARB_STARVE_GUARD_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic i_win,
  output logic d_win
);

  logic force_i;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;

  assign force_i = i_req && (starve_cnt_reg >= LIMIT);

  // Only data grants made while the fetch is actually waiting count; any
  // fetch grant, or the fetch going away, restarts the count. Saturates so a
  // long stall can never wrap back below the limit.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!i_req || i_win) begin
      starve_cnt_next = 4'd0;
    end else if (d_win && (starve_cnt_reg != 4'hF)) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  assign d_win = arb_en && d_req && !force_i;
  assign i_win = arb_en && i_req && !d_win;

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between instruction fetch and
// MEM-stage data accesses. One transaction is granted per cycle at most; the
// grant drives the memory command combinationally in the same cycle. Reads
// (loads and fetches) return m_rdata to the owning port exactly RD_LATENCY
// cycles after the grant; stores complete in the grant cycle.
// Optional feature macro: ARB_STARVE_GUARD_EN (bounded fetch wait, see
// mem_arb_prio). Default build: strict data priority.
// Parameters: DATA_LEN, MEM_ADDR_LEN, RD_LATENCY (1..4), STARVE_LIMIT (1..15)
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : mem_port_arbiter_if.slave (fetch, data, memory ports and busy)
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_LEN     = 32,
  parameter int MEM_ADDR_LEN = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
)(
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  if ((RD_LATENCY < 1) || (RD_LATENCY > 4)) begin : g_bad_rd_latency
    $error("mem_port_arbiter: RD_LATENCY must be in 1..4");
  end
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY);

  arb_state_e state_reg, state_next;
  owner_e     owner_reg, owner_next;
  logic [2:0] lat_cnt_reg, lat_cnt_next;

  logic final_cycle;
  logic arb_en;
  logic i_win;
  logic d_win;

  // The counter reads 1 in the cycle the memory data is valid; that cycle
  // both returns data and may accept the next request.
  assign final_cycle = (state_reg == ARB_WAIT) && (lat_cnt_reg == 3'd1);
  // Grants are suppressed while reset is held so every output reads 0.
  assign arb_en = !reset && ((state_reg == ARB_IDLE) || final_cycle);

  mem_arb_prio
`ifdef ARB_STARVE_GUARD_EN
  #(
    .STARVE_LIMIT (STARVE_LIMIT)
  )
`endif
  u_prio (
`ifdef ARB_STARVE_GUARD_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .arb_en (arb_en),
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
    .i_win  (i_win),
    .d_win  (d_win)
  );

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    lat_cnt_next = lat_cnt_reg;

    bus.i_gnt    = 1'b0;
    bus.d_gnt    = 1'b0;
    bus.i_rvalid = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rdata  = '0;
    bus.m_en     = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_addr   = '0;
    bus.m_wdata  = '0;
    bus.m_fn     = MEM_FN_NONE;

    // Read in flight: count down, deliver data on the final cycle.
    if (state_reg == ARB_WAIT) begin
      lat_cnt_next = lat_cnt_reg - 3'd1;
      if (final_cycle) begin
        state_next   = ARB_IDLE;
        lat_cnt_next = 3'd0;
        if (owner_reg == OWN_D) begin
          bus.d_rvalid = 1'b1;
          bus.d_rdata  = bus.m_rdata;
        end else begin
          bus.i_rvalid = 1'b1;
          bus.i_rdata  = bus.m_rdata;
        end
      end
    end

    // New grant; a read granted here overrides the return to idle above.
    if (d_win) begin
      bus.d_gnt   = 1'b1;
      bus.m_en    = 1'b1;
      bus.m_we    = bus.d_we;
      bus.m_addr  = bus.d_addr;
      bus.m_wdata = bus.d_wdata;
      bus.m_fn    = bus.d_fn;
      if (!bus.d_we) begin
        state_next   = ARB_WAIT;
        owner_next   = OWN_D;
        lat_cnt_next = LAT_INIT;
      end
    end else if (i_win) begin
      bus.i_gnt    = 1'b1;
      bus.m_en     = 1'b1;
      bus.m_addr   = bus.i_addr;
      state_next   = ARB_WAIT;
      owner_next   = OWN_I;
      lat_cnt_next = LAT_INIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ARB_IDLE;
      owner_reg   <= OWN_I;
      lat_cnt_reg <= 3'd0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      lat_cnt_reg <= lat_cnt_next;
    end
  end

  assign bus.busy = (state_reg == ARB_WAIT);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the instruction-fetch requester and the MEM-stage data requester of the 5-stage RV32I pipeline. Grants one transaction at a time, issues it to the memory, times the fixed read latency and returns read data to the owning requester. Data requests have priority by default; a compile-time starvation guard bounds fetch wait.

## Interface
- DATA_LEN, 32: data width.
- MEM_ADDR_LEN, 32: byte-address width.
- RD_LATENCY, 1: memory read latency in cycles; legal range 1..4.
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits (guard builds only); legal range 1..15.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  MEM_ADDR_LEN  fetch address.
- i_gnt  out  1  one-cycle grant pulse for the fetch.
- i_rvalid  out  1  fetch read data valid, one cycle.
- i_rdata  out  DATA_LEN  fetch data; m_rdata when i_rvalid, else 0.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_fn stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  MEM_ADDR_LEN  data address.
- d_wdata  in  DATA_LEN  store data.
- d_fn  in  3  pipeline mem_fn code, passed to memory unchanged.
- d_gnt  out  1  one-cycle grant pulse for data.
- d_rvalid  out  1  load data valid, one cycle.
- d_rdata  out  DATA_LEN  load data; m_rdata when d_rvalid, else 0.
- m_en, m_we  out  1 each  memory access strobe / write enable.
- m_addr  out  MEM_ADDR_LEN; m_wdata  out  DATA_LEN; m_fn  out  3  memory command.
- m_rdata  in  DATA_LEN  memory read data, valid RD_LATENCY cycles after m_en.
- busy  out  1  read in flight.

## Operation
- FSM states ARB_IDLE, ARB_WAIT; registers: state, owner (OWN_I/OWN_D), latency counter (3 bits), starvation counter (4 bits, guard only).
- Grant allowed when state is ARB_IDLE, or ARB_WAIT with counter at its final cycle (rvalid cycle).
- Arbitration: d_req wins; i_req wins when d_req low, or when guard forces fetch.
- Grant cycle: gnt pulse, m_en=1, m_addr/m_we/m_wdata/m_fn driven combinationally from the winner (fetch: m_we=0, m_fn=0, m_wdata=0). m_* all 0 when no grant.
- Store grant: complete in the grant cycle, no rvalid, state stays/returns ARB_IDLE.
- Load/fetch grant: owner latched, counter loaded with RD_LATENCY, state to ARB_WAIT; counter decrements each cycle; rvalid on owner's port when counter reaches 1, state to ARB_IDLE unless a new read is granted that same cycle.
- A request dropped before its grant issues nothing.
- busy = (state == ARB_WAIT).

## Timing
- Reset: state ARB_IDLE, counters 0, owner OWN_I; all outputs 0.
- Reset mid-read: pending rvalid discarded; no rvalid after reset release.
- Read latency: rvalid exactly RD_LATENCY cycles after grant.
- Throughput: back-to-back reads every RD_LATENCY cycles; stores every cycle.
- Simultaneous i_req and d_req: exactly one gnt per cycle; loser holds request.
- Grant in rvalid cycle: rvalid for old owner and gnt for new requester in the same cycle, on possibly different ports.

## Configuration
- ARB_STARVE_GUARD_EN defined: starvation counter increments on each data grant while i_req high, clears on fetch grant or while i_req low; at STARVE_LIMIT the next arbitration grants fetch even with d_req high.
- Undefined: strict data priority; counter not built; STARVE_LIMIT ignored.

## Structure
- Shared package mem_arb_pkg: state encoding ARB_IDLE/ARB_WAIT, owner encoding OWN_I/OWN_D, mem_fn code constants shared with the decoder.
- One sub-module: mem_arb_prio (combinational winner select plus starvation counter, guard-conditional).

## Test plan
- Reset then d_req load at addr 0x40, RD_LATENCY=2, m_rdata=0xDEADBEEF → d_gnt at t, m_en at t, d_rvalid with d_rdata=0xDEADBEEF at t+2, i_rvalid stays 0.
- i_req and d_req load asserted same cycle → d_gnt first; i_gnt in d_rvalid cycle; i_rvalid RD_LATENCY later.
- Four consecutive d_we=1 stores, addrs 0x0..0xC → d_gnt and m_we=1 every cycle, no rvalid, busy 0.
- Guard on, STARVE_LIMIT=2, d_req held high, i_req high, RD_LATENCY=1 → grants D, D, I, D, D, I; guard off → I never granted while d_req high.
- reset asserted in ARB_WAIT one cycle after a fetch grant → outputs 0 immediately; no i_rvalid after release; next i_req granted in first cycle after release.
